// File: rtl/axil_reg_pkg.sv
// Shared AXI-Lite register-bank types: response codes and address-region decode.
package axil_reg_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      REG_STAT,
      REG_CTRL,
      REG_NONE
   } reg_region_e;

endpackage

// File: rtl/axil_stat_reg_bank_if.sv
// AXI-Lite slave bus bundle (32-bit address and data) for the statistics/control register bank.
interface axil_stat_reg_bank_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic        rvalid;
   logic        rready;
   logic [31:0] rdata;
   logic [1:0]  rresp;

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axil_reg_decode.sv
// Combinational byte address -> (region, word index within region) decode.
module axil_reg_decode
   import axil_reg_pkg::*;
#(
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned N_STAT    = 10,
   parameter int unsigned N_CTRL    = 10,
   parameter int unsigned CTRL_BASE = 32'h40,
   parameter int unsigned IDX_W     = 4
) (
   input  logic [31:0]      addr,
   output reg_region_e      region_c,
   output logic [IDX_W-1:0] idx_c
);
   localparam int unsigned CTRL_WORD = CTRL_BASE / 4;

   logic [31:0] word_c;
   logic        addr_unused;

   // Byte lane and bits above the decoded window do not take part in decode.
   assign word_c      = 32'(addr[ADDR_W-1:2]);
   assign addr_unused = ^{addr[31:ADDR_W], addr[1:0]};

   always_comb begin
      region_c = REG_NONE;
      idx_c    = '0;
      if (word_c < N_STAT) begin
         region_c = REG_STAT;
         idx_c    = IDX_W'(word_c);
      end else if ((word_c >= CTRL_WORD) && (word_c < CTRL_WORD + N_CTRL)) begin
         region_c = REG_CTRL;
         idx_c    = IDX_W'(word_c - CTRL_WORD);
      end
   end
endmodule

// File: rtl/axil_stat_reg_bank.sv
// AXI-Lite bank of read-only statistics words and read/write host control words.
// Optional STAT_CLEAR_ON_READ_EN: a successful statistics read pulses stat_clr for that word.
module axil_stat_reg_bank
   import axil_reg_pkg::*;
#(
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned N_STAT    = 10,
   parameter int unsigned N_CTRL    = 10,
   parameter int unsigned CTRL_BASE = 32'h40
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   axil_stat_reg_bank_if.slave   s_axil,
   input  logic [32*N_STAT-1:0]  statistics,
   output logic [32*N_CTRL-1:0]  host_data,
   output logic [N_STAT-1:0]     stat_clr
);
   localparam int unsigned N_MAX = (N_STAT > N_CTRL) ? N_STAT : N_CTRL;
   localparam int unsigned IDX_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;

   reg_region_e      aw_region_c;
   reg_region_e      ar_region_c;
   logic [IDX_W-1:0] aw_idx_c;
   logic [IDX_W-1:0] ar_idx_c;
   logic             aw_hs_c;
   logic             ar_hs_c;
   logic [31:0]      rd_word_c;
   logic             bvalid;
   logic [1:0]       bresp;
   logic             rvalid;
   logic [1:0]       rresp;
   logic [31:0]      rdata;

   axil_reg_decode #(
      .ADDR_W(ADDR_W), .N_STAT(N_STAT), .N_CTRL(N_CTRL), .CTRL_BASE(CTRL_BASE), .IDX_W(IDX_W)
   ) u_aw_decode (
      .addr(s_axil.awaddr), .region_c(aw_region_c), .idx_c(aw_idx_c)
   );

   axil_reg_decode #(
      .ADDR_W(ADDR_W), .N_STAT(N_STAT), .N_CTRL(N_CTRL), .CTRL_BASE(CTRL_BASE), .IDX_W(IDX_W)
   ) u_ar_decode (
      .addr(s_axil.araddr), .region_c(ar_region_c), .idx_c(ar_idx_c)
   );

   // AW and W are only taken together, and only while no write response is pending.
   assign aw_hs_c        = aresetn && s_axil.awvalid && s_axil.wvalid && !bvalid;
   assign ar_hs_c        = aresetn && s_axil.arvalid && !rvalid;
   assign s_axil.awready = aw_hs_c;
   assign s_axil.wready  = aw_hs_c;
   assign s_axil.arready = ar_hs_c;
   assign s_axil.bvalid  = bvalid;
   assign s_axil.bresp   = bresp;
   assign s_axil.rvalid  = rvalid;
   assign s_axil.rresp   = rresp;
   assign s_axil.rdata   = rdata;

   // Write channel: byte-masked control update and response.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         bvalid    <= 1'b0;
         bresp     <= RESP_OKAY;
         host_data <= '0;
      end else begin
         if (aw_hs_c) begin
            bvalid <= 1'b1;
            bresp  <= (aw_region_c == REG_CTRL) ? RESP_OKAY : RESP_SLVERR;
         end else if (s_axil.bready) begin
            bvalid <= 1'b0;
         end
         for (int i = 0; i < int'(N_CTRL); i++) begin
            for (int b = 0; b < 4; b++) begin
               if (aw_hs_c && (aw_region_c == REG_CTRL) && (aw_idx_c == IDX_W'(i)) && s_axil.wstrb[b])
                  host_data[32*i+8*b +: 8] <= s_axil.wdata[8*b +: 8];
            end
         end
      end
   end

   // Read mux: sampled at the AR handshake edge, so same-edge writes are not visible.
   always_comb begin
      rd_word_c = '0;
      for (int i = 0; i < int'(N_STAT); i++)
         if ((ar_region_c == REG_STAT) && (ar_idx_c == IDX_W'(i))) rd_word_c = statistics[32*i +: 32];
      for (int i = 0; i < int'(N_CTRL); i++)
         if ((ar_region_c == REG_CTRL) && (ar_idx_c == IDX_W'(i))) rd_word_c = host_data[32*i +: 32];
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rvalid <= 1'b0;
         rresp  <= RESP_OKAY;
         rdata  <= '0;
      end else if (ar_hs_c) begin
         rvalid <= 1'b1;
         rresp  <= (ar_region_c == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
         rdata  <= rd_word_c;
      end else if (s_axil.rready) begin
         rvalid <= 1'b0;
      end
   end

`ifdef STAT_CLEAR_ON_READ_EN
   // One-cycle clear strobe in the cycle after a statistics read is accepted.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         stat_clr <= '0;
      end else begin
         for (int i = 0; i < int'(N_STAT); i++)
            stat_clr[i] <= ar_hs_c && (ar_region_c == REG_STAT) && (ar_idx_c == IDX_W'(i));
      end
   end
`else
   assign stat_clr = '0;
`endif
endmodule

// File: tb/tb_axil_stat_reg_bank.sv
// Directed self-checking bench for axil_stat_reg_bank (default parameters).
module tb_axil_stat_reg_bank;
   localparam int unsigned N_STAT = 10;
   localparam int unsigned N_CTRL = 10;

   logic                 aclk;
   logic                 aresetn;
   logic [32*N_STAT-1:0] statistics;
   logic [32*N_CTRL-1:0] host_data;
   logic [N_STAT-1:0]    stat_clr;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   axil_stat_reg_bank_if s_axil();

   axil_stat_reg_bank #(
      .ADDR_W(12), .N_STAT(N_STAT), .N_CTRL(N_CTRL), .CTRL_BASE(32'h40)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .s_axil(s_axil),
      .statistics(statistics), .host_data(host_data), .stat_clr(stat_clr)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $fatal(1, "FAIL watchdog: observed no finish, expected finish before 200000");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Starts and ends at posedge+1.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
      logic acc;
      acc  = 1'b0;
      resp = 2'bxx;
      s_axil.awaddr = addr; s_axil.wdata = data; s_axil.wstrb = strb;
      s_axil.awvalid = 1'b1; s_axil.wvalid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         #1 acc = s_axil.awready;
         @(posedge aclk); #1;
         if (acc) break;
      end
      s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0;
      chk("aw_accept", 32'(acc), 32'd1);
      acc = 1'b0;
      s_axil.bready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (s_axil.bvalid) begin acc = 1'b1; resp = s_axil.bresp; end
         @(posedge aclk); #1;
         if (acc) break;
      end
      s_axil.bready = 1'b0;
      chk("b_valid", 32'(acc), 32'd1);
   endtask

   task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output logic [31:0] clr0,
                          output logic [31:0] clr1);
      logic acc;
      acc  = 1'b0;
      data = 'x; resp = 'x; clr0 = 'x;
      s_axil.araddr = addr; s_axil.arvalid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         #1 acc = s_axil.arready;
         @(posedge aclk); #1;
         if (acc) break;
      end
      s_axil.arvalid = 1'b0;
      chk("ar_accept", 32'(acc), 32'd1);
      acc = 1'b0;
      s_axil.rready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (s_axil.rvalid) begin
            acc = 1'b1; data = s_axil.rdata; resp = s_axil.rresp; clr0 = 32'(stat_clr);
         end
         @(posedge aclk); #1;
         if (acc) break;
      end
      clr1 = 32'(stat_clr);
      s_axil.rready = 1'b0;
      chk("r_valid", 32'(acc), 32'd1);
   endtask

   initial begin
      logic [1:0]           resp;
      logic [31:0]          data;
      logic [31:0]          clr0;
      logic [31:0]          clr1;
      logic [31:0]          exp_clr;
      logic [32*N_CTRL-1:0] saved;

      aresetn = 1'b0;
      s_axil.awvalid = 1'b0; s_axil.awaddr = '0; s_axil.wvalid = 1'b0;
      s_axil.wdata = '0; s_axil.wstrb = '0; s_axil.bready = 1'b0;
      s_axil.arvalid = 1'b0; s_axil.araddr = '0; s_axil.rready = 1'b0;
      for (int i = 0; i < int'(N_STAT); i++) statistics[32*i +: 32] = 32'(1000 + i);

      // Reset state
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_awready", 32'(s_axil.awready), 32'd0);
      chk("rst_arready", 32'(s_axil.arready), 32'd0);
      chk("rst_bvalid",  32'(s_axil.bvalid),  32'd0);
      chk("rst_rvalid",  32'(s_axil.rvalid),  32'd0);
      chk("rst_bresp",   32'(s_axil.bresp),   32'd0);
      chk("rst_rresp",   32'(s_axil.rresp),   32'd0);
      chk("rst_rdata",   s_axil.rdata,        32'd0);
      chk("rst_stat_clr", 32'(stat_clr),      32'd0);
      for (int i = 0; i < int'(N_CTRL); i++)
         chk($sformatf("rst_host%0d", i), host_data[32*i +: 32], 32'd0);
      aresetn = 1'b1;
      @(posedge aclk); #1;

      // Control writes and read-back
      for (int i = 0; i < int'(N_CTRL); i++) begin
         do_write(32'h40 + 32'(4*i), 32'(100 + i), 4'hF, resp);
         chk($sformatf("wr_ctrl%0d_bresp", i), 32'(resp), 32'd0);
      end
      for (int i = 0; i < int'(N_CTRL); i++) begin
         chk($sformatf("host%0d", i), host_data[32*i +: 32], 32'(100 + i));
         do_read(32'h40 + 32'(4*i), data, resp, clr0, clr1);
         chk($sformatf("rd_ctrl%0d_data", i), data, 32'(100 + i));
         chk($sformatf("rd_ctrl%0d_rresp", i), 32'(resp), 32'd0);
      end

      // Statistics reads
      for (int i = 0; i < int'(N_STAT); i++) begin
`ifdef STAT_CLEAR_ON_READ_EN
         exp_clr = 32'd1 << i;
`else
         exp_clr = 32'd0;
`endif
         do_read(32'(4*i), data, resp, clr0, clr1);
         chk($sformatf("rd_stat%0d_data", i), data, 32'(1000 + i));
         chk($sformatf("rd_stat%0d_rresp", i), 32'(resp), 32'd0);
         chk($sformatf("stat%0d_clr_pulse", i), clr0, exp_clr);
         chk($sformatf("stat%0d_clr_after", i), clr1, 32'd0);
      end

      // Byte-strobe write over a zeroed word
      do_write(32'h44, 32'h0000_0000, 4'hF, resp);
      do_write(32'h44, 32'hAABB_CCDD, 4'b0101, resp);
      chk("strb_bresp", 32'(resp), 32'd0);
      chk("strb_host1", host_data[32 +: 32], 32'h00BB_00DD);

      // Writes to stat/unmapped space, unmapped and boundary reads, address aliasing
      saved = host_data;
      do_write(32'h08, 32'hFFFF_FFFF, 4'hF, resp);
      chk("wr_stat_bresp", 32'(resp), 32'd2);
      do_write(32'h68, 32'hFFFF_FFFF, 4'hF, resp);
      chk("wr_unmap_bresp", 32'(resp), 32'd2);
      for (int i = 0; i < int'(N_CTRL); i++)
         chk($sformatf("unchanged_host%0d", i), host_data[32*i +: 32], saved[32*i +: 32]);
      do_read(32'h80, data, resp, clr0, clr1);
      chk("rd_unmap80_data", data, 32'd0);
      chk("rd_unmap80_rresp", 32'(resp), 32'd2);
      chk("rd_unmap80_clr", clr0, 32'd0);
      do_read(32'h28, data, resp, clr0, clr1);
      chk("rd_unmap28_data", data, 32'd0);
      chk("rd_unmap28_rresp", 32'(resp), 32'd2);
      do_read(32'h24, data, resp, clr0, clr1);
      chk("rd_stat_last", data, 32'd1009);
      do_read(32'h64, data, resp, clr0, clr1);
      chk("rd_ctrl_last", data, 32'd109);
      do_read(32'h1044, data, resp, clr0, clr1);
      chk("rd_alias_high", data, 32'h00BB_00DD);
      do_read(32'h47, data, resp, clr0, clr1);
      chk("rd_alias_low", data, 32'h00BB_00DD);
      chk("rd_alias_rresp", 32'(resp), 32'd0);

      // Simultaneous AR + AW/W to the same word, then 5 stalled response cycles
      s_axil.awaddr = 32'h48; s_axil.wdata = 32'h1234_5678; s_axil.wstrb = 4'hF;
      s_axil.araddr = 32'h48;
      s_axil.awvalid = 1'b1; s_axil.wvalid = 1'b1; s_axil.arvalid = 1'b1;
      #1;
      chk("same_cyc_awready", 32'(s_axil.awready), 32'd1);
      chk("same_cyc_arready", 32'(s_axil.arready), 32'd1);
      @(posedge aclk); #1;
      s_axil.wdata = 32'hDEAD_BEEF; s_axil.araddr = 32'h4C;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("stall_bvalid",  32'(s_axil.bvalid),  32'd1);
         chk("stall_bresp",   32'(s_axil.bresp),   32'd0);
         chk("stall_awready", 32'(s_axil.awready), 32'd0);
         chk("stall_rvalid",  32'(s_axil.rvalid),  32'd1);
         chk("stall_rdata",   s_axil.rdata,        32'd102);
         chk("stall_rresp",   32'(s_axil.rresp),   32'd0);
         chk("stall_arready", 32'(s_axil.arready), 32'd0);
         @(posedge aclk); #1;
      end
      s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0; s_axil.arvalid = 1'b0;
      s_axil.bready = 1'b1; s_axil.rready = 1'b1;
      @(posedge aclk); #1;
      s_axil.bready = 1'b0; s_axil.rready = 1'b0;
      chk("drain_bvalid", 32'(s_axil.bvalid), 32'd0);
      chk("drain_rvalid", 32'(s_axil.rvalid), 32'd0);
      chk("same_cyc_host2", host_data[64 +: 32], 32'h1234_5678);
      chk("same_cyc_host3", host_data[96 +: 32], 32'd103);

      // Reset while a write response is pending
      s_axil.awaddr = 32'h4C; s_axil.wdata = 32'h55; s_axil.wstrb = 4'hF;
      s_axil.awvalid = 1'b1; s_axil.wvalid = 1'b1;
      @(posedge aclk); #1;
      s_axil.awvalid = 1'b0; s_axil.wvalid = 1'b0;
      chk("pre_rst_bvalid", 32'(s_axil.bvalid), 32'd1);
      #2 aresetn = 1'b0;
      #1;
      chk("mid_rst_bvalid", 32'(s_axil.bvalid), 32'd0);
      chk("mid_rst_bresp",  32'(s_axil.bresp),  32'd0);
      chk("mid_rst_host2",  host_data[64 +: 32], 32'd0);
      chk("mid_rst_host3",  host_data[96 +: 32], 32'd0);
      @(posedge aclk); @(posedge aclk); #1;
      aresetn = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge aclk); #1;
         chk("post_rst_bvalid", 32'(s_axil.bvalid), 32'd0);
         chk("post_rst_rvalid", 32'(s_axil.rvalid), 32'd0);
      end
      do_read(32'h4C, data, resp, clr0, clr1);
      chk("post_rst_rd_data", data, 32'd0);
      chk("post_rst_rd_rresp", 32'(resp), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
